// File: rtl/led_pwm_periph.sv
// LED / RGB PWM peripheral.
// A small register file (CTRL, DUTY, PRESCALE, STATUS) sits on a simple
// strobe bus. It drives a static LED and three PWM colour channels. The PWM
// timebase is a 16-bit prescaler feeding an 8-bit period counter. Duty values
// are double-buffered so that a period is never altered once it has started.
module led_pwm_periph #(
  parameter logic [15:0] PRESCALE_RST   = 16'd46,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  // Register indices decoded from addr[3:2]; addr[1:0] is a byte offset and is ignored
  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_DUTY     = 2'd1,
    REG_PRESCALE = 2'd2,
    REG_STATUS   = 2'd3
  } reg_sel_e;

  // Convert a logical "lit" request into the physical pin level
  function automatic logic pin_drive(input logic lit);
    return LED_ACTIVE_LOW ? ~lit : lit;
  endfunction

  // Compare a channel's shadow duty against the period counter
  function automatic logic pwm_lit(input logic en, input logic [7:0] cnt,
                                   input logic [7:0] duty);
    return en && (cnt < duty);
  endfunction

  reg_sel_e    sel;

  // Software-visible registers
  logic        ctrl_en;
  logic        ctrl_led;
  logic [23:0] duty;
  logic [15:0] prescale;
  logic        status_flag;

  // Timebase and shadow duties
  logic [15:0] psc_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  shadow_r;
  logic [7:0]  shadow_g;
  logic [7:0]  shadow_b;

  // Compare stage outputs (combinational, feed the pin flops)
  logic        psc_wrap_p0;
  logic        tick_p0;
  logic        boundary_p0;
  logic        lit_r_p0;
  logic        lit_g_p0;
  logic        lit_b_p0;
  logic        lit_led_p0;

  // Pin flops
  logic        led_p1;
  logic        rgb_r_p1;
  logic        rgb_g_p1;
  logic        rgb_b_p1;

  // Bus side
  logic        wr_ctrl;
  logic        wr_duty;
  logic        wr_prescale;
  logic        wr_status;
  logic [31:0] rd_mux;

  // Address bits and write-data bits that no register uses
  logic        unused_bits;

  assign sel         = reg_sel_e'(addr[3:2]);
  assign unused_bits = ^{addr[1:0], wdata[31:24]};

  assign wr_ctrl     = wr_en && (sel == REG_CTRL);
  assign wr_duty     = wr_en && (sel == REG_DUTY);
  assign wr_prescale = wr_en && (sel == REG_PRESCALE);
  assign wr_status   = wr_en && (sel == REG_STATUS);

  // Register write port; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_led <= 1'b0;
      duty     <= 24'd0;
      prescale <= PRESCALE_RST;
    end else begin
      if (wr_ctrl) begin
        ctrl_en  <= wdata[0];
        ctrl_led <= wdata[1];
      end
      if (wr_duty) begin
        duty <= wdata[23:0];
      end
      if (wr_prescale) begin
        prescale <= wdata[15:0];
      end
    end
  end

  // ---- stage p0: timebase compare ----
  // Prescaler wraps at >= so a PRESCALE lowered below the running count wraps on the next cycle
  always_comb begin
    psc_wrap_p0 = (psc_cnt >= prescale);
    tick_p0     = ctrl_en && psc_wrap_p0;
    boundary_p0 = tick_p0 && (pwm_cnt == 8'hFF);
  end

  // Prescaler and PWM period counter, both held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) begin
      psc_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
    end else begin
      psc_cnt <= psc_wrap_p0 ? 16'd0 : psc_cnt + 16'd1;
      if (tick_p0) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
    end
  end

  // Shadow duties track DUTY while disabled, otherwise reload only at the period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= 8'd0;
      shadow_g <= 8'd0;
      shadow_b <= 8'd0;
    end else if (!ctrl_en || boundary_p0) begin
      shadow_r <= duty[7:0];
      shadow_g <= duty[15:8];
      shadow_b <= duty[23:16];
    end
  end

  // Sticky period-boundary flag; a new boundary outranks a same-cycle clear so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      status_flag <= 1'b0;
    end else if (boundary_p0) begin
      status_flag <= 1'b1;
    end else if (wr_status) begin
      status_flag <= 1'b0;
    end
  end

  // Per-channel lit decision from the current count and shadow duty
  always_comb begin
    lit_r_p0   = pwm_lit(ctrl_en, pwm_cnt, shadow_r);
    lit_g_p0   = pwm_lit(ctrl_en, pwm_cnt, shadow_g);
    lit_b_p0   = pwm_lit(ctrl_en, pwm_cnt, shadow_b);
    lit_led_p0 = ctrl_led;
  end

  // ---- stage p1: pin flops, polarity applied here only ----
  // Registered pin drives; reset forces every pin dark
  always_ff @(posedge clk) begin
    if (rst) begin
      led_p1   <= pin_drive(1'b0);
      rgb_r_p1 <= pin_drive(1'b0);
      rgb_g_p1 <= pin_drive(1'b0);
      rgb_b_p1 <= pin_drive(1'b0);
    end else begin
      led_p1   <= pin_drive(lit_led_p0);
      rgb_r_p1 <= pin_drive(lit_r_p0);
      rgb_g_p1 <= pin_drive(lit_g_p0);
      rgb_b_p1 <= pin_drive(lit_b_p0);
    end
  end

  assign LED   = led_p1;
  assign RGB_R = rgb_r_p1;
  assign RGB_G = rgb_g_p1;
  assign RGB_B = rgb_b_p1;

  // Read multiplexer over the pre-write register contents
  always_comb begin
    rd_mux = 32'd0;
    unique case (sel)
      REG_CTRL:     rd_mux = {30'd0, ctrl_led, ctrl_en};
      REG_DUTY:     rd_mux = {8'd0, duty};
      REG_PRESCALE: rd_mux = {16'd0, prescale};
      REG_STATUS:   rd_mux = {23'd0, status_flag, pwm_cnt};
      default:      rd_mux = 32'd0;
    endcase
  end

  // Read response: one-cycle rvalid pulse, rdata held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule
